// File: rtl/pc_gen_if.sv
// rtl/pc_gen_if.sv - fetch PC generator bus: ex control, BTB training and fetch outputs
//
// Purpose: groups every non-clock/reset signal of pc_gen into one bundle.
// Ports (signals):
//   i_hold_flag[1:0]      ex hold/flush code (01 = hold, 10 = flush, other = run)
//   i_jump_en             ex redirect request
//   i_jump_addr[31:0]     redirect target, bits [1:0] ignored
//   i_bp_upd_en           BTB training strobe
//   i_bp_upd_pc[31:0]     PC of the resolved branch
//   i_bp_upd_target[31:0] resolved target
//   i_bp_upd_taken        resolved direction
//   o_pc_addr[31:0]       current fetch PC
//   o_pred_taken          BTB predicts o_pc_addr taken
//   o_pred_target[31:0]   predicted target, 0 when not predicted
// Modports: master = ex/fetch side driving controls, slave = pc_gen.
interface pc_gen_if;
  logic [1:0]  i_hold_flag;
  logic        i_jump_en;
  logic [31:0] i_jump_addr;
  logic        i_bp_upd_en;
  logic [31:0] i_bp_upd_pc;
  logic [31:0] i_bp_upd_target;
  logic        i_bp_upd_taken;
  logic [31:0] o_pc_addr;
  logic        o_pred_taken;
  logic [31:0] o_pred_target;

  modport master (
    output i_hold_flag, i_jump_en, i_jump_addr,
    output i_bp_upd_en, i_bp_upd_pc, i_bp_upd_target, i_bp_upd_taken,
    input  o_pc_addr, o_pred_taken, o_pred_target
  );

  modport slave (
    input  i_hold_flag, i_jump_en, i_jump_addr,
    input  i_bp_upd_en, i_bp_upd_pc, i_bp_upd_target, i_bp_upd_taken,
    output o_pc_addr, o_pred_taken, o_pred_target
  );
endinterface

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch-stage PC generator with direct-mapped BTB and 2-bit counters
//
// Purpose: registers the fetch PC and picks the next one from (in priority order)
// an ex redirect, a pipeline hold, a taken BTB prediction, or PC+4.
// Ports:
//   i_Clk       clock, rising edge
//   i_reset_n   synchronous active-low reset
//   bus         pc_gen_if.slave: ex controls, BTB training, fetch PC and prediction
module pc_gen #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BTB_ENTRIES = 16,
  parameter int          IDX_W       = 4
) (
  input  logic     i_Clk,
  input  logic     i_reset_n,
  pc_gen_if.slave  bus
);

  localparam int         TAG_W     = 32 - IDX_W - 2;
  localparam logic [1:0] HOLD_CODE = 2'b01;

  logic [31:0]      pc_q;
  logic [31:0]      pc_d;

  logic             valid_q  [BTB_ENTRIES];
  logic [TAG_W-1:0] tag_q    [BTB_ENTRIES];
  logic [31:0]      target_q [BTB_ENTRIES];
  logic [1:0]       ctr_q    [BTB_ENTRIES];

  // Lookup for the current fetch PC; always sees pre-update BTB contents.
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic             pred_taken;

  assign lk_idx     = pc_q[IDX_W+1:2];
  assign lk_tag     = pc_q[31:IDX_W+2];
  assign lk_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken = lk_hit && ctr_q[lk_idx][1];

  assign bus.o_pc_addr     = pc_q;
  assign bus.o_pred_taken  = pred_taken;
  assign bus.o_pred_target = pred_taken ? target_q[lk_idx] : 32'h0;

  // Jump overrides hold; flush code falls through to prediction/sequential.
  always_comb begin
    pc_d = pc_q + 32'd4;
    if (bus.i_jump_en) begin
      pc_d = {bus.i_jump_addr[31:2], 2'b00};
    end else if (bus.i_hold_flag == HOLD_CODE) begin
      pc_d = pc_q;
    end else if (pred_taken) begin
      pc_d = {target_q[lk_idx][31:2], 2'b00};
    end
  end

  // Training side, independent of the PC path.
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic [1:0]       up_ctr_d;

  assign up_idx = bus.i_bp_upd_pc[IDX_W+1:2];
  assign up_tag = bus.i_bp_upd_pc[31:IDX_W+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  // Saturating 2-bit counter step.
  always_comb begin
    up_ctr_d = ctr_q[up_idx];
    if (bus.i_bp_upd_taken) begin
      if (ctr_q[up_idx] != 2'b11) up_ctr_d = ctr_q[up_idx] + 2'd1;
    end else begin
      if (ctr_q[up_idx] != 2'b00) up_ctr_d = ctr_q[up_idx] - 2'd1;
    end
  end

  // Low address bits are architecturally ignored.
  logic unused_low_bits;
  assign unused_low_bits = ^{bus.i_jump_addr[1:0], bus.i_bp_upd_pc[1:0]};

  // Tag/target need no reset: valid gates every use of them.
  always_ff @(posedge i_Clk) begin
    if (!i_reset_n) begin
      pc_q <= RESET_PC;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
    end else begin
      pc_q <= pc_d;
      if (bus.i_bp_upd_en) begin
        if (up_hit) begin
          target_q[up_idx] <= bus.i_bp_upd_target;
          ctr_q[up_idx]    <= up_ctr_d;
        end else if (bus.i_bp_upd_taken) begin
          valid_q[up_idx]  <= 1'b1;
          tag_q[up_idx]    <= up_tag;
          target_q[up_idx] <= bus.i_bp_upd_target;
          ctr_q[up_idx]    <= 2'b10;
        end
      end
    end
  end

endmodule
